bytecode_fetch: RTL

// Instruction fetch front end of the bytecode core. Reads JVM bytecode bytes from

---
 rtl/bytecode_fetch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bytecode_fetch.sv
`timescale 1ns/1ps
// bytecode_fetch
// Instruction fetch front end of the bytecode core. It reads the opcode byte
// from byte-wide program memory, then 0, 1 or 2 operand bytes depending on
// the opcode, and presents {opcode, operand, nargs, instr_pc} to the decoder
// over a valid/ready handshake. Only one instruction is ever in flight.
// A branch redirect from execute (jump_en) aborts whatever fetch is under way.
//
// Ports
//   clk          core clock, all state changes on the rising edge
//   rst          synchronous reset, active-low
//   mem_addr     program memory byte address (registered)
//   mem_rd       read strobe; mem_data is valid during the cycle mem_rd is high
//                and is captured at the end of that cycle
//   mem_data     program memory read data
//   instr_valid  opcode/operand/nargs/instr_pc hold a complete instruction
//   instr_ready  consumer accepts when instr_valid && instr_ready
//   opcode       instruction opcode byte
//   operand      operand bytes, big-endian, zero-extended when only one byte
//   nargs        number of operand bytes (0..2)
//   instr_pc     address of the opcode byte
//   jump_en      redirect request, one-cycle pulse
//   jump_addr    redirect target address

module bytecode_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            opcode,
  output logic [15:0]           operand,
  output logic [1:0]            nargs,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr
);

  typedef enum logic [2:0] {
    REQ_OP,
    CAP_OP,
    REQ_A1,
    CAP_A1,
    REQ_A2,
    CAP_A2,
    ISSUE
  } state_t;

  // Operand byte count for each opcode; anything not listed carries none.
  function automatic logic [1:0] operand_count(input logic [7:0] op);
    if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA7))
      return 2'd2;  // sipush, iinc, if*/goto
    else if (op == 8'h10 || op == 8'h12 || op == 8'h15 || op == 8'h36)
      return 2'd1;  // bipush, ldc, iload, istore
    else
      return 2'd0;
  endfunction

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [7:0]            byte1;         // high operand byte while the low one is read
  logic [1:0]            fetched_nargs;

  assign fetched_nargs = operand_count(mem_data);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= REQ_OP;
      pc          <= RESET_PC;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      instr_valid <= 1'b0;
      opcode      <= 8'h00;
      operand     <= 16'h0000;
      nargs       <= 2'd0;
      instr_pc    <= '0;
      byte1       <= 8'h00;
    end else if (jump_en) begin
      // Redirect wins over everything: any pending read is dropped by not
      // capturing it, and a handshake in the same cycle still completes.
      pc          <= jump_addr;
      state       <= REQ_OP;
      mem_rd      <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      // The strobe lasts a single cycle; only the REQ states raise it again.
      mem_rd <= 1'b0;
      unique case (state)
        REQ_OP, REQ_A1, REQ_A2: begin
          mem_addr <= pc;
          mem_rd   <= 1'b1;
          pc       <= pc + ADDR_WIDTH'(1);  // wraps to 0 past the top address
          state    <= (state == REQ_OP) ? CAP_OP :
                      (state == REQ_A1) ? CAP_A1 : CAP_A2;
        end
        CAP_OP: begin
          opcode   <= mem_data;
          instr_pc <= pc - ADDR_WIDTH'(1);
          operand  <= 16'h0000;
          nargs    <= fetched_nargs;
          if (fetched_nargs == 2'd0) begin
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end else begin
            state <= REQ_A1;
          end
        end
        CAP_A1: begin
          if (nargs == 2'd1) begin
            operand     <= {8'h00, mem_data};
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end else begin
            byte1 <= mem_data;
            state <= REQ_A2;
          end
        end
        CAP_A2: begin
          operand     <= {byte1, mem_data};
          instr_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= REQ_OP;
          end
        end
        default: state <= REQ_OP;
      endcase
    end
  end

endmodule
